// File: rtl/memstream_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : memstream_pkg
//  Brief   : Shared types and constants for the memstream loader.
//  Revision: 1.0
// ============================================================================
package memstream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } state_t;

    localparam int CFG_WIDTH = 32;

    function automatic int stream_width(input int w);
        return ((w + 7) / 8) * 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/memstream_loader.sv
`default_nettype none
// ============================================================================
//  Module  : memstream_loader
//  Brief   : Fills the memstream weight memory from AXI-Stream, then releases
//            the memstream reset. A start in RUN reloads the memory.
//  Revision: 1.0
// ============================================================================
module memstream_loader
    import memstream_pkg::*;
#(
    parameter int MEM_DEPTH     = 13824,
    parameter int MEM_WIDTH     = 32,
    parameter int RELEASE_DELAY = 4
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic                                start,
    input  logic [stream_width(MEM_WIDTH)-1:0]  s_axis_tdata,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    output logic [CFG_WIDTH-1:0]                config_address,
    output logic                                config_ce,
    output logic                                config_we,
    output logic [CFG_WIDTH-1:0]                config_d0,
    output logic                                strm_aresetn,
    output logic                                busy,
    output logic                                done
);

    localparam int c_sw       = stream_width(MEM_WIDTH);
    localparam int c_cnt_w    = $clog2(MEM_DEPTH);
    localparam int c_settle_w = $clog2(RELEASE_DELAY + 1);

    localparam logic [c_cnt_w-1:0]    c_last_word   = c_cnt_w'(MEM_DEPTH - 1);
    localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(RELEASE_DELAY);
    localparam logic [c_sw-1:0]       c_data_mask   = c_sw'((64'd1 << MEM_WIDTH) - 64'd1);

    state_t                  r_state;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [c_settle_w-1:0]   r_settle;
    logic                    r_ce;
    logic [CFG_WIDTH-1:0]    r_addr;
    logic [CFG_WIDTH-1:0]    r_d0;
    logic                    r_strm;
    logic                    r_done;

    logic                    w_hs;

    assign s_axis_tready  = (r_state == LOAD);
    assign w_hs           = s_axis_tvalid && s_axis_tready;
    assign busy           = (r_state == LOAD) || (r_state == SETTLE);
    assign config_ce      = r_ce;
    assign config_we      = r_ce;
    assign config_address = r_addr;
    assign config_d0      = r_d0;
    assign strm_aresetn   = r_strm;
    assign done           = r_done;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_settle <= '0;
            r_ce     <= 1'b0;
            r_addr   <= '0;
            r_d0     <= '0;
            r_strm   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_ce <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= LOAD;
                        r_cnt   <= '0;
                    end
                end
                LOAD: begin
                    if (w_hs) begin
                        r_ce   <= 1'b1;
                        r_addr <= CFG_WIDTH'(r_cnt);
                        r_d0   <= CFG_WIDTH'(s_axis_tdata & c_data_mask);
                        if (r_cnt == c_last_word) begin
                            r_state  <= SETTLE;
                            r_settle <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                // First SETTLE cycle shows the final write; RELEASE_DELAY more follow.
                SETTLE: begin
                    if (r_settle == c_settle_last) begin
                        r_state <= RUN;
                        r_strm  <= 1'b1;
                        r_done  <= 1'b1;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                RUN: begin
                    if (start) begin
                        r_state <= LOAD;
                        r_cnt   <= '0;
                        r_strm  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memstream_loader.sv
`default_nettype none
// ============================================================================
//  Module  : tb_memstream_loader
//  Brief   : Directed scoreboard bench for memstream_loader (depth 8, 12-bit).
//  Revision: 1.0
// ============================================================================
module tb_memstream_loader;

    localparam int DEPTH = 8;
    localparam int WIDTH = 12;
    localparam int RDLY  = 4;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [31:0] cfg_addr;
    logic        cfg_ce;
    logic        cfg_we;
    logic [31:0] cfg_d0;
    logic        strm_rstn;
    logic        busy;
    logic        done;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] sb_q[$];
    int unsigned exp_addr = 0;
    int          n_writes = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;

    memstream_loader #(
        .MEM_DEPTH    (DEPTH),
        .MEM_WIDTH    (WIDTH),
        .RELEASE_DELAY(RDLY)
    ) dut (
        .aclk          (clk),
        .aresetn       (aresetn),
        .start         (start),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .config_address(cfg_addr),
        .config_ce     (cfg_ce),
        .config_we     (cfg_we),
        .config_d0     (cfg_d0),
        .strm_aresetn  (strm_rstn),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: predict handshake, advance, then score any config write.
    task automatic tick();
        logic        hs;
        logic [63:0] e;
        hs = tvalid && tready;
        if (hs) begin
            sb_q.push_back({exp_addr, 32'(tdata & 16'h0FFF)});
            exp_addr++;
        end
        @(posedge clk);
        #1;
        chk("ce_after_handshake", {31'd0, cfg_ce}, {31'd0, hs});
        if (cfg_ce === 1'b1) begin
            n_writes++;
            chk("we_with_ce", {31'd0, cfg_we}, 32'd1);
            if (sb_q.size() == 0) begin
                chk("write_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("write_addr", cfg_addr, e[63:32]);
                chk("write_data", cfg_d0, e[31:0]);
                last_addr = e[63:32];
                last_data = e[31:0];
            end
        end else begin
            chk("we_idle", {31'd0, cfg_we}, 32'd0);
            chk("addr_hold", cfg_addr, last_addr);
            chk("data_hold", cfg_d0, last_data);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_addr = 0;
        n_writes = 0;
    endtask

    // Stream DEPTH words; optional bubble after each and a start on word start_at.
    task automatic load_words(input logic [15:0] base, input bit bubbles, input int start_at);
        for (int i = 0; i < DEPTH; i++) begin
            chk("tready_in_load", {31'd0, tready}, 32'd1);
            chk("done_in_load", {31'd0, done}, 32'd0);
            chk("busy_in_load", {31'd0, busy}, 32'd1);
            tvalid = 1'b1;
            tdata  = base + 16'(i);
            start  = (i == start_at);
            tick();
            start = 1'b0;
            if (bubbles && i != DEPTH - 1) begin
                tvalid = 1'b0;
                tdata  = 16'hDEAD;
                tick();
            end
        end
        chk("tready_after_last", {31'd0, tready}, 32'd0);
        chk("busy_after_last", {31'd0, busy}, 32'd1);
    endtask

    // tvalid stays high through SETTLE to prove no extra word is taken.
    task automatic wait_release(input bit start_in_settle);
        int n;
        n = 0;
        tdata = 16'hBEEF;
        while (strm_rstn !== 1'b1 && n < 20) begin
            start = start_in_settle && (n == 1);
            tick();
            start = 1'b0;
            n++;
        end
        tvalid = 1'b0;
        chk("release_edges", 32'(n), 32'(RDLY + 1));
        chk("done_at_release", {31'd0, done}, 32'd1);
        chk("busy_at_release", {31'd0, busy}, 32'd0);
        chk("tready_in_run", {31'd0, tready}, 32'd0);
        chk("write_count", 32'(n_writes), 32'(DEPTH));
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        // 1: reset with tvalid high, then idle without start
        tvalid = 1'b1;
        tdata  = 16'h1234;
        #12;
        chk("rst_tready", {31'd0, tready}, 32'd0);
        chk("rst_ce", {31'd0, cfg_ce}, 32'd0);
        chk("rst_we", {31'd0, cfg_we}, 32'd0);
        chk("rst_addr", cfg_addr, 32'd0);
        chk("rst_d0", cfg_d0, 32'd0);
        chk("rst_strm", {31'd0, strm_rstn}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_tready", {31'd0, tready}, 32'd0);
            chk("idle_strm", {31'd0, strm_rstn}, 32'd0);
        end
        tvalid = 1'b0;

        // 2: back-to-back load
        pulse_start();
        load_words(16'hFFA0, 1'b0, -1);
        wait_release(1'b0);

        // 4: reload from RUN
        tick();
        pulse_start();
        chk("reload_strm", {31'd0, strm_rstn}, 32'd0);
        chk("reload_done", {31'd0, done}, 32'd0);
        chk("reload_busy", {31'd0, busy}, 32'd1);
        load_words(16'hF0B0, 1'b0, -1);
        wait_release(1'b0);

        // 3: toggling tvalid
        pulse_start();
        load_words(16'hA5C0, 1'b1, -1);
        wait_release(1'b0);

        // 5: async reset after 3 words
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            tvalid = 1'b1;
            tdata  = 16'h7700 + 16'(i);
            tick();
        end
        #2;
        aresetn = 1'b0;
        #1;
        chk("arst_ce", {31'd0, cfg_ce}, 32'd0);
        chk("arst_addr", cfg_addr, 32'd0);
        chk("arst_d0", cfg_d0, 32'd0);
        chk("arst_tready", {31'd0, tready}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_strm", {31'd0, strm_rstn}, 32'd0);
        sb_q.delete();
        last_addr = '0;
        last_data = '0;
        tvalid = 1'b0;
        #3;
        aresetn = 1'b1;
        tick();
        tick();
        chk("post_arst_strm", {31'd0, strm_rstn}, 32'd0);
        pulse_start();
        load_words(16'h0C10, 1'b0, -1);
        wait_release(1'b0);

        // 6: start ignored during LOAD and SETTLE
        pulse_start();
        load_words(16'h3D20, 1'b0, 3);
        wait_release(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
